// File: rtl/reset_sequencer.sv
// reset_sequencer: releases STAGES downstream blocks one at a time in order.
// Each release waits for a settle delay and then for that stage's ready
// feedback. The whole chain restarts on PLL lock loss, a forced restart, or
// a released stage dropping ready. A saturating restart count and a sticky
// timeout error are reported for the OSD/debug path.
//
// Stage handshake: stage_release[k] is the request and stage_done[k] the
// acknowledge. A release is never withdrawn except by a full-chain restart,
// and a stage's done must stay high for as long as its release is high;
// a done that falls while its release is high restarts the chain.
module reset_sequencer #(
    parameter int STAGES        = 2,
    parameter int DELAY_WIDTH   = 24,
    parameter int TIMEOUT_WIDTH = 24,
    localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     locked,
    input  logic [DELAY_WIDTH-1:0]   startup_delay,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    input  logic                     force_restart,
    input  logic [STAGES-1:0]        stage_done,
    output logic [STAGES-1:0]        stage_release,
    output logic                     all_ready,
    output logic [CW-1:0]            current_stage,
    output logic [7:0]               restart_count,
    output logic                     error,
    output logic [1:0]               fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DELAY     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                   state_q;
    logic                     locked_meta_q;
    logic                     locked_s_q;
    logic [DELAY_WIDTH-1:0]   dcnt_q;
    logic [TIMEOUT_WIDTH-1:0] tcnt_q;
    logic [CW-1:0]            k_q;
    logic [STAGES-1:0]        release_q;
    logic                     all_ready_q;
    logic [7:0]               restart_count_q;
    logic                     error_q;

    logic [STAGES-1:0]        lower_mask;
    logic [STAGES-1:0]        k_bit;
    logic                     done_k;
    logic                     k_last;
    logic                     ready_lost;
    logic                     restart_req;
    logic                     timeout_hit;
    logic [7:0]               restart_count_d;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
        end
    end

    // Decode the current stage index into masks and the restart/timeout causes.
    always_comb begin
        lower_mask = '0;
        k_bit      = '0;
        for (int j = 0; j < STAGES; j++) begin
            if (j < int'(k_q)) lower_mask[j] = 1'b1;
            if (j == int'(k_q)) k_bit[j] = 1'b1;
        end
        done_k = |(stage_done & k_bit);
        k_last = (k_q == CW'(STAGES - 1));
        if (state_q == ST_RUN) begin
            ready_lost = !(&stage_done);
        end else begin
            ready_lost = ((stage_done & lower_mask) != lower_mask);
        end
        restart_req = (state_q != ST_IDLE) &&
                      (!locked_s_q || force_restart || ready_lost);
        timeout_hit = (state_q == ST_WAIT_DONE) &&
                      (timeout != '0) &&
                      (tcnt_q == timeout - TIMEOUT_WIDTH'(1));
        restart_count_d = (restart_count_q == 8'hFF) ? 8'hFF
                                                     : restart_count_q + 8'd1;
    end

    // Sequencer FSM with registered outputs; a restart or timeout overrides progress.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q         <= ST_IDLE;
            dcnt_q          <= '0;
            tcnt_q          <= '0;
            k_q             <= '0;
            release_q       <= '0;
            all_ready_q     <= 1'b0;
            restart_count_q <= 8'd0;
            error_q         <= 1'b0;
        end else begin
            if (timeout_hit) error_q <= 1'b1;
            if (restart_req || timeout_hit) begin
                state_q         <= ST_IDLE;
                release_q       <= '0;
                all_ready_q     <= 1'b0;
                k_q             <= '0;
                dcnt_q          <= '0;
                tcnt_q          <= '0;
                restart_count_q <= restart_count_d;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        release_q   <= '0;
                        all_ready_q <= 1'b0;
                        k_q         <= '0;
                        if (locked_s_q) begin
                            state_q <= ST_DELAY;
                            dcnt_q  <= startup_delay;
                        end
                    end
                    ST_DELAY: begin
                        if (dcnt_q == '0) begin
                            state_q   <= ST_WAIT_DONE;
                            release_q <= release_q | k_bit;
                            tcnt_q    <= '0;
                        end else begin
                            dcnt_q <= dcnt_q - DELAY_WIDTH'(1);
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (done_k) begin
                            if (k_last) begin
                                state_q     <= ST_RUN;
                                all_ready_q <= 1'b1;
                            end else begin
                                k_q     <= k_q + CW'(1);
                                state_q <= ST_DELAY;
                                dcnt_q  <= startup_delay;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TIMEOUT_WIDTH'(1);
                        end
                    end
                    ST_RUN: begin
                        all_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign stage_release = release_q;
    assign all_ready     = all_ready_q;
    assign current_stage = k_q;
    assign restart_count = restart_count_q;
    assign error         = error_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by randomized
// traffic, with a cycle-level reference model feeding an expected queue that
// a negedge monitor drains against the DUT outputs.
module tb_reset_sequencer;

    localparam int S  = 2;
    localparam int DW = 8;
    localparam int TW = 8;
    localparam int CW = 1;

    typedef struct packed {
        logic          busy;
        logic [S-1:0]  rel;
        logic          all;
        logic [CW-1:0] cur;
        logic [7:0]    cnt;
        logic          err;
    } exp_t;
    localparam int W = $bits(exp_t);

    // ---------------- clock / reset / DUT ----------------
    logic          clock;
    logic          nreset;
    logic          locked;
    logic [DW-1:0] startup_delay;
    logic [TW-1:0] timeout;
    logic          force_restart;
    logic [S-1:0]  stage_done;
    logic [S-1:0]  stage_release;
    logic          all_ready;
    logic [CW-1:0] current_stage;
    logic [7:0]    restart_count;
    logic          error;
    logic [1:0]    fsm_state;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    reset_sequencer #(
        .STAGES(S), .DELAY_WIDTH(DW), .TIMEOUT_WIDTH(TW)
    ) u_dut (
        .clock(clock), .nreset(nreset), .locked(locked),
        .startup_delay(startup_delay), .timeout(timeout),
        .force_restart(force_restart), .stage_done(stage_done),
        .stage_release(stage_release), .all_ready(all_ready),
        .current_stage(current_stage), .restart_count(restart_count),
        .error(error), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Chain described as: how many stages have completed (m_k), whether we
    // are settling before a release, waiting for done, or fully running.
    logic         m_h1, m_h2;
    bit           m_active, m_settling, m_waiting, m_running, m_err;
    int           m_k, m_settle, m_waited, m_cnt;
    logic [S-1:0] m_rel;

    function automatic logic [S-1:0] ones(input int n);
        logic [S-1:0] r;
        r = '0;
        for (int j = 0; j < S; j++) if (j < n) r[j] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        bit ls, healthy, to;
        logic [S-1:0] need;
        if (!nreset) begin
            m_h1 = 0; m_h2 = 0;
            m_active = 0; m_settling = 0; m_waiting = 0; m_running = 0;
            m_k = 0; m_settle = 0; m_waited = 0; m_cnt = 0; m_err = 0;
        end else begin
            ls   = m_h2;
            m_h2 = m_h1;
            m_h1 = locked;
            if (!m_active) begin
                if (ls) begin
                    m_active = 1; m_settling = 1; m_k = 0;
                    m_settle = int'(startup_delay);
                end
            end else begin
                need    = m_running ? ones(S) : ones(m_k);
                healthy = ls && !force_restart && ((stage_done & need) == need);
                to      = m_waiting && (timeout != 0) && (m_waited == int'(timeout) - 1);
                if (to) m_err = 1;
                if (!healthy || to) begin
                    m_active = 0; m_settling = 0; m_waiting = 0; m_running = 0;
                    m_k = 0;
                    if (m_cnt < 255) m_cnt++;
                end else if (m_settling) begin
                    if (m_settle == 0) begin
                        m_settling = 0; m_waiting = 1; m_waited = 0;
                    end else begin
                        m_settle--;
                    end
                end else if (m_waiting) begin
                    if (stage_done[m_k]) begin
                        m_waiting = 0;
                        if (m_k == S - 1) begin
                            m_running = 1;
                        end else begin
                            m_k++;
                            m_settling = 1;
                            m_settle = int'(startup_delay);
                        end
                    end else begin
                        m_waited = (m_waited + 1) % (1 << TW);
                    end
                end
            end
        end
        if (!m_active)      m_rel = '0;
        else if (m_running) m_rel = ones(S);
        else if (m_settling) m_rel = ones(m_k);
        else                m_rel = ones(m_k + 1);
    endtask

    // Model advances on every active edge and queues the expected outputs.
    always @(posedge clock) begin
        exp_t x;
        model_step();
        x.busy = m_active;
        x.rel  = m_rel;
        x.all  = m_running;
        x.cur  = m_k[CW-1:0];
        x.cnt  = m_cnt[7:0];
        x.err  = m_err;
        exp_q.push_back(x);
    end

    // Monitor: compare DUT outputs on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            check("sb_release", int'(stage_release), int'(e.rel));
            check("sb_all_ready", int'(all_ready), int'(e.all));
            check("sb_current_stage", int'(current_stage), int'(e.cur));
            check("sb_restart_count", int'(restart_count), int'(e.cnt));
            check("sb_error", int'(error), int'(e.err));
            check("sb_busy", int'(fsm_state != 2'd0), int'(e.busy));
        end
    end

    // ---------------- driver ----------------
    int           age[S];
    int           lat[S];
    logic [S-1:0] blk;
    bit           tie;

    // One clock: stage feedback follows the expected release after lat cycles.
    task automatic tick();
        @(posedge clock);
        #2;
        for (int j = 0; j < S; j++) begin
            if (m_rel[j]) age[j]++;
            else age[j] = 0;
            stage_done[j] = tie || (m_rel[j] && age[j] >= lat[j] && !blk[j]);
        end
    endtask

    task automatic pulse_force();
        force_restart = 1'b1;
        tick();
        force_restart = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n = 0;
        while (!all_ready && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(all_ready), 1);
    endtask

    task automatic wait_release0(input string name, input int exp_n);
        int n = 0;
        while (!stage_release[0] && n < 100) begin
            tick();
            n++;
        end
        check(name, n, exp_n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int prev;
        nreset = 0; locked = 0; startup_delay = 0; timeout = 0;
        force_restart = 0; stage_done = '0; blk = '0; tie = 0;
        for (int j = 0; j < S; j++) begin age[j] = 0; lat[j] = 5; end
        repeat (3) tick();
        check("reset_release", int'(stage_release), 0);
        check("reset_count", int'(restart_count), 0);
        check("reset_error", int'(error), 0);

        // Normal bring-up: delay 10, no timeout.
        nreset = 1; locked = 1; startup_delay = 8'd10;
        wait_release0("rel0_latency", 14);
        wait_ready("bringup_ready", 100);
        check("bringup_count", int'(restart_count), 0);
        check("bringup_error", int'(error), 0);
        repeat (4) tick();

        // Lock loss in RUN for 3 cycles.
        locked = 0;
        repeat (2) tick();
        check("lockloss_pre", int'(all_ready), 1);
        tick();
        check("lockloss_release", int'(stage_release), 0);
        check("lockloss_ready", int'(all_ready), 0);
        check("lockloss_count", int'(restart_count), 1);
        locked = 1;
        wait_ready("relock_ready", 200);

        // Timeout on stage 1.
        timeout = 8'd20; blk = 2'b10;
        n = 0;
        while (!error && n < 200) begin tick(); n++; end
        check("timeout_error", int'(error), 1);
        check("timeout_release", int'(stage_release), 0);
        repeat (100) tick();
        check("timeout_sticky", int'(error), 1);
        blk = '0; timeout = 8'd0;
        wait_ready("retry_ready", 200);
        check("retry_error_kept", int'(error), 1);
        nreset = 0;
        tick();
        check("nreset_error_clear", int'(error), 0);
        check("nreset_count_clear", int'(restart_count), 0);
        nreset = 1;

        // Stage 0 drops ready while stage 1 settles.
        n = 0;
        while (!(m_k == 1 && m_settling) && n < 100) begin tick(); n++; end
        check("drop_reached", int'(m_k == 1 && m_settling), 1);
        prev = m_cnt;
        stage_done[0] = 1'b0;
        tick();
        check("drop_stage", int'(current_stage), 0);
        check("drop_release", int'(stage_release), 0);
        check("drop_count", int'(restart_count), prev + 1);

        // force_restart in IDLE is ignored; in WAIT_DONE it counts.
        locked = 0;
        repeat (6) tick();
        prev = m_cnt;
        pulse_force();
        tick();
        check("force_idle_count", int'(restart_count), prev);
        locked = 1;
        n = 0;
        while (!m_waiting && n < 100) begin tick(); n++; end
        prev = m_cnt;
        pulse_force();
        check("force_wait_count", int'(restart_count), prev + 1);

        // 300 forced restarts saturate the counter.
        startup_delay = 8'd3;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            while (!m_active && n < 20) begin tick(); n++; end
            pulse_force();
        end
        check("saturate_count", int'(restart_count), 255);

        // nreset in the middle of DELAY clears everything next edge.
        startup_delay = 8'd10;
        n = 0;
        while (!m_settling && n < 20) begin tick(); n++; end
        nreset = 0;
        tick();
        check("middelay_release", int'(stage_release), 0);
        check("middelay_ready", int'(all_ready), 0);
        check("middelay_stage", int'(current_stage), 0);
        check("middelay_count", int'(restart_count), 0);

        // Zero delay, stage feedback tied high.
        startup_delay = 8'd0; tie = 1;
        nreset = 1;
        wait_release0("zero_delay_rel0", 4);
        wait_ready("zero_delay_ready", 10);
        tie = 0;

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 49) == 0) startup_delay = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0)
                timeout = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 25));
            if ($urandom_range(0, 79) == 0)
                for (int j = 0; j < S; j++) lat[j] = $urandom_range(0, 30);
            if (locked) locked = ($urandom_range(0, 199) != 0);
            else        locked = ($urandom_range(0, 3) == 0);
            force_restart = ($urandom_range(0, 149) == 0);
            nreset = ($urandom_range(0, 599) != 0);
            tick();
            if ($urandom_range(0, 99) == 0) stage_done[$urandom_range(0, S - 1)] = 1'b0;
        end
        nreset = 1; force_restart = 0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
